// File: rtl/tp_pkg.sv
// Shared definitions for the touch-panel key scanner: default coordinate width,
// key FSM states and a width helper.
package tp_pkg;

  localparam int COORD_W_DEF = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAND    = 2'd1,
    PRESSED = 2'd2,
    REL     = 2'd3
  } state_t;

  // Bits needed to index n items. Never returns less than 1.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/tp_grid_map.sv
// Combinational coordinate-to-pad mapper. Column and row come from a comparator
// chain against the cell boundaries, so no divider is needed.
module tp_grid_map #(
  parameter int COORD_W = 12,
  parameter int COLS    = 4,
  parameter int ROWS    = 4,
  parameter int X_MIN   = 200,
  parameter int Y_MIN   = 200,
  parameter int CELL_W  = 900,
  parameter int CELL_H  = 900,
  parameter int KEY_W   = 4
) (
  input  logic [COORD_W-1:0] xaxis,
  input  logic [COORD_W-1:0] yaxis,
  input  logic               pen_down,
  output logic               hit,
  output logic [KEY_W-1:0]   code
);

  logic [31:0] xw;
  logic [31:0] yw;
  logic        x_in;
  logic        y_in;
  int          col_i;
  int          row_i;

  assign xw = 32'(xaxis);
  assign yw = 32'(yaxis);

  always_comb begin
    col_i = 0;
    row_i = 0;
    for (int k = 1; k < COLS; k++) begin
      if (xw >= 32'(X_MIN + k * CELL_W)) col_i++;
    end
    for (int k = 1; k < ROWS; k++) begin
      if (yw >= 32'(Y_MIN + k * CELL_H)) row_i++;
    end
    // Upper edges are exclusive: the first coordinate past the grid is a miss.
    x_in = (xw >= 32'(X_MIN)) && (xw < 32'(X_MIN + COLS * CELL_W));
    y_in = (yw >= 32'(Y_MIN)) && (yw < 32'(Y_MIN + ROWS * CELL_H));
    hit  = pen_down && x_in && y_in;
    code = KEY_W'(row_i * COLS + col_i);
  end

endmodule

// File: rtl/touch_key_scanner.sv
// Touch-panel key scanner: registered grid mapping followed by a debounce,
// press/release and hold FSM that runs once per qualified sample.
module touch_key_scanner
  import tp_pkg::*;
#(
  parameter int COORD_W  = COORD_W_DEF,
  parameter int COLS     = 4,
  parameter int ROWS     = 4,
  parameter int X_MIN    = 200,
  parameter int Y_MIN    = 200,
  parameter int CELL_W   = 900,
  parameter int CELL_H   = 900,
  parameter int DEBOUNCE = 4,
  parameter int HOLD     = 64
) (
  input  logic                          TP_DCLK,
  input  logic                          rst,
  input  logic [COORD_W-1:0]            xaxis,
  input  logic [COORD_W-1:0]            yaxis,
  input  logic                          pen_down,
  input  logic                          sample_valid,
  output logic [clog2(ROWS*COLS)-1:0]   key,
  output logic                          key_valid,
  output logic                          press,
  // Release pulse; the bare word is reserved in SystemVerilog.
  output logic                          key_release,
  output logic                          hold
);

  localparam int KEY_W = clog2(ROWS * COLS);
  localparam int CW    = clog2(DEBOUNCE + 1);
  localparam int HW    = clog2(HOLD + 1);

  function automatic logic [HW-1:0] sat_inc(input logic [HW-1:0] v);
    return (v == HW'(HOLD)) ? v : v + 1'b1;
  endfunction

  logic             hit_p0;
  logic [KEY_W-1:0] code_p0;
  logic             hit_p1;
  logic [KEY_W-1:0] code_p1;
  logic             vld_p1;

  state_t           state;
  logic [KEY_W-1:0] cand;
  logic [CW-1:0]    cnt;
  logic [HW-1:0]    hold_cnt;
  logic [HW-1:0]    hold_nxt;
  logic             same_cand;
  logic             same_key;
  logic             deb_done;

  tp_grid_map #(
    .COORD_W(COORD_W), .COLS(COLS), .ROWS(ROWS), .X_MIN(X_MIN), .Y_MIN(Y_MIN),
    .CELL_W(CELL_W), .CELL_H(CELL_H), .KEY_W(KEY_W)
  ) u_map (
    .xaxis   (xaxis),
    .yaxis   (yaxis),
    .pen_down(pen_down),
    .hit     (hit_p0),
    .code    (code_p0)
  );

  // ---- stage 1: mapped sample register ----
  always_ff @(posedge TP_DCLK) begin
    hit_p1  <= hit_p0;
    code_p1 <= code_p0;
  end

  always_ff @(posedge TP_DCLK or posedge rst) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= sample_valid;
  end

  // ---- stage 2: key FSM ----
  assign same_cand = hit_p1 && (code_p1 == cand);
  assign same_key  = hit_p1 && (code_p1 == key);
  assign deb_done  = (cnt == CW'(DEBOUNCE - 1));
  assign hold_nxt  = sat_inc(hold_cnt);
  assign key_valid = (state == PRESSED) || (state == REL);

  always_ff @(posedge TP_DCLK or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cand        <= '0;
      cnt         <= '0;
      hold_cnt    <= '0;
      key         <= '0;
      press       <= 1'b0;
      key_release <= 1'b0;
      hold        <= 1'b0;
    end else begin
      press       <= 1'b0;
      key_release <= 1'b0;
      if (vld_p1) begin
        case (state)
          IDLE: begin
            if (hit_p1) begin
              cand <= code_p1;
              cnt  <= CW'(1);
              if (DEBOUNCE == 1) begin
                state    <= PRESSED;
                key      <= code_p1;
                press    <= 1'b1;
                hold_cnt <= '0;
              end else begin
                state <= CAND;
              end
            end
          end
          CAND: begin
            if (same_cand) begin
              if (deb_done) begin
                state    <= PRESSED;
                key      <= cand;
                press    <= 1'b1;
                hold_cnt <= '0;
                hold     <= 1'b0;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end else if (hit_p1) begin
              cand <= code_p1;
              cnt  <= CW'(1);
            end else begin
              state <= IDLE;
              cnt   <= '0;
            end
          end
          PRESSED: begin
            if (same_key) begin
              hold_cnt <= hold_nxt;
              hold     <= (hold_nxt == HW'(HOLD));
            end else if (DEBOUNCE == 1) begin
              state       <= IDLE;
              key_release <= 1'b1;
              hold        <= 1'b0;
              hold_cnt    <= '0;
              cnt         <= '0;
            end else begin
              state <= REL;
              cnt   <= CW'(1);
            end
          end
          REL: begin
            // Samples here never seed a new candidate; a new pad starts from IDLE.
            if (same_key) begin
              state <= PRESSED;
            end else if (deb_done) begin
              state       <= IDLE;
              key_release <= 1'b1;
              hold        <= 1'b0;
              hold_cnt    <= '0;
              cnt         <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/touch_key_scanner.md
# touch_key_scanner

Parametrised touch-panel key scanner for the drum-pad front end. It takes raw 12-bit X/Y coordinates from the touch-panel controller and maps them onto a ROWS×COLS grid of pads. Each key is debounced over consecutive samples, and the block emits a registered key index, one-cycle press/release pulses and a hold flag to the sound/display logic. It replaces the fixed 4-bit single-shot key decode with configurable geometry, debounce and hold detection.

## Interface
Parameters:
- COORD_W, 12, coordinate width
- COLS, 4, pad columns
- ROWS, 4, pad rows
- X_MIN, 200, left edge of pad area
- Y_MIN, 200, top edge of pad area
- CELL_W, 900, pad width in coordinate units
- CELL_H, 900, pad height in coordinate units
- DEBOUNCE, 4, consecutive matching samples to accept a press or a release (≥1)
- HOLD, 64, samples in PRESSED before `hold` asserts (≥1)

Ports (KEY_W = clog2(ROWS*COLS), 4 by default):
- TP_DCLK, in, 1, the block's single clock
- rst, in, 1, asynchronous, active-high reset
- xaxis, in, COORD_W, X coordinate
- yaxis, in, COORD_W, Y coordinate
- pen_down, in, 1, panel currently touched; qualified by sample_valid
- sample_valid, in, 1, one-cycle strobe marking a new coordinate sample
- key, out, KEY_W, index of the currently pressed key, row*COLS+col
- key_valid, out, 1, a key is in the pressed state
- press, out, 1, one-cycle pulse when a key becomes pressed
- release, out, 1, one-cycle pulse when the pressed key is released
- hold, out, 1, pressed key has been held for HOLD samples

## Operation
Stage 1, mapping (registered):
- col = number of boundaries X_MIN + k*CELL_W (k=1..COLS-1) that are ≤ x. Found by comparator chain, no divider.
- x inside the pad area iff X_MIN ≤ x < X_MIN+COLS*CELL_W. Rows are mapped the same way from y.
- The sample is a hit iff pen_down is high and both x and y are inside the area. Otherwise it is a miss.
- Stage register holds {hit, code} plus stg_valid.

Stage 2, FSM. It advances only when stg_valid is high. cnt counts consecutive matching samples.
- IDLE: a hit loads cand=code, cnt=1, and moves to CAND. If DEBOUNCE==1 it goes directly to PRESSED.
- CAND: a hit with the same code does cnt+1. When cnt reaches DEBOUNCE: go to PRESSED, key=cand, pulse press. A hit with a different code reloads cand, cnt=1. A miss returns to IDLE.
- PRESSED: a hit with the same code increments the hold counter, saturating. When it reaches HOLD, `hold` asserts. Any miss or different code moves to REL with cnt=1. If DEBOUNCE==1, release happens immediately.
- REL: a miss or different code does cnt+1. When cnt reaches DEBOUNCE, pulse release and go to IDLE. A hit with the pressed code returns to PRESSED; the hold count is kept and no pulses are generated.
- key_valid is high in PRESSED and REL. `key` holds its last value after release. hold clears on release.
- Sliding to a neighbouring pad always produces a release first. The new pad then needs a full debounce starting from IDLE, so samples seen during REL do not count toward it.

## Timing
- Reset values: key=0, key_valid=0, press=0, release=0, hold=0. FSM=IDLE, counters=0, stg_valid=0.
- Latency: a sample with sample_valid in cycle t is registered at the t→t+1 edge. The FSM acts on it at the next edge, so outputs change in cycle t+2.
- press and release are exactly one TP_DCLK cycle wide and never assert together.
- sample_valid in consecutive cycles is supported at full rate.
- A reset asserted mid-press clears everything immediately, with no release pulse.
- Out-of-area samples (including exactly X_MIN+COLS*CELL_W) are misses.

## Structure
- A shared package, tp_pkg, holds:
  - the COORD_W default;
  - the state enum (IDLE, CAND, PRESSED, REL);
  - a clog2 helper function.
- One sub-module, tp_grid_map, implements the comparator-chain coordinate→{hit, code} mapper. It is instantiated once for stage 1.

## Test plan
- Reset, then 4 valid samples at (650,650) with pen_down → press in cycle t4+2, key=0, key_valid=1.
- 4 samples at (2000,3000) → key=14. Then 4 samples at (199,650) → release pulse, key_valid=0, key stays 14.
- Boundary: x=1100,y=650 → key=1. x=3800 → no press after any number of samples.
- Glitch: 3 samples on key 5, 1 miss, 3 samples on key 5 → no press. A 4th consecutive sample → press, key=5.
- 68 samples held on key 9 → press after sample 4, hold after sample 68. Then 4 pen-up samples → release, hold=0.
- Assert rst while in PRESSED → all outputs 0 next cycle, no release pulse. Post-reset, 4 samples → normal press.
